// File: rtl/hm01b0_capture_ctrl.sv
// HM01B0 4-bit capture sequencer: frame-aligned arming, nibble packing, linear frame-buffer writes, end-of-frame status.
// Optional 2x subsampling under HM01B0_CAPTURE_DECIMATE_EN.
module hm01b0_capture_ctrl #(
  parameter int WIDTH  = 324,
  parameter int HEIGHT = 244,
  parameter int ADDR_W = 17
) (
  input  logic              hm01b0_pixclk,
  input  logic              reset,
  input  logic [3:0]        pixdata,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              arm,
  input  logic              continuous,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       line_count,
  output logic [15:0]       last_line_len
);

`ifdef HM01B0_CAPTURE_DECIMATE_EN
  localparam int  LIMIT = (WIDTH / 2) * (HEIGHT / 2);
  localparam bit  DECIM = 1'b1;
`else
  localparam int  LIMIT = WIDTH * HEIGHT;
  localparam bit  DECIM = 1'b0;
`endif
  localparam logic [ADDR_W:0] LIMIT_V  = LIMIT[ADDR_W:0];
  localparam logic [15:0]     WIDTH_V  = WIDTH[15:0];
  localparam logic [15:0]     HEIGHT_V = HEIGHT[15:0];

  typedef enum logic [2:0] {IDLE, SYNC, WAIT_FRAME, CAPTURE, DONE} state_t;

  state_t          state, state_nxt;
  logic            hsync_q;
  logic            phase;
  logic [3:0]      nib_hi;
  logic [ADDR_W:0] wr_cnt;
  logic [15:0]     line_cnt;
  logic [15:0]     line_bytes;
  logic [15:0]     last_len_int;
  logic            err_acc;

  logic start, pix_vld, byte_done, line_end, keep, room;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (arm) state_nxt = SYNC;
      SYNC:       if (!vsync) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (vsync) state_nxt = CAPTURE;
      CAPTURE:    if (!vsync) state_nxt = DONE;
      DONE:       state_nxt = (continuous && arm) ? SYNC : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign start     = (state == WAIT_FRAME) && vsync;
  assign pix_vld   = (state == CAPTURE) && vsync && hsync;
  assign byte_done = pix_vld && phase;
  assign line_end  = (state == CAPTURE) && hsync_q && !hsync;
  // Subsampling keeps even lines and even byte columns of each line.
  assign keep      = DECIM ? (!line_cnt[0] && !line_bytes[0]) : 1'b1;
  assign room      = (wr_cnt < LIMIT_V);

  always_ff @(posedge hm01b0_pixclk) begin
    if (!reset) begin
      state         <= IDLE;
      hsync_q       <= 1'b0;
      phase         <= 1'b0;
      nib_hi        <= '0;
      wr_cnt        <= '0;
      line_cnt      <= '0;
      line_bytes    <= '0;
      last_len_int  <= '0;
      err_acc       <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_err     <= 1'b0;
      line_count    <= '0;
      last_line_len <= '0;
    end else begin
      state   <= state_nxt;
      hsync_q <= hsync;
      wr_en   <= 1'b0;
      if (start) begin
        phase         <= 1'b0;
        wr_cnt        <= '0;
        wr_addr       <= '0;
        line_cnt      <= '0;
        line_bytes    <= '0;
        last_len_int  <= '0;
        err_acc       <= 1'b0;
        frame_err     <= 1'b0;
        line_count    <= '0;
        last_line_len <= '0;
      end else if (state == CAPTURE) begin
        if (pix_vld) begin
          phase <= ~phase;
          if (!phase) nib_hi <= pixdata;
        end
        if (byte_done) begin
          line_bytes <= sat_inc(line_bytes);
          if (keep) begin
            if (room) begin
              wr_en   <= 1'b1;
              wr_addr <= wr_cnt[ADDR_W-1:0];
              wr_data <= {nib_hi, pixdata};
              wr_cnt  <= wr_cnt + 1'b1;
            end else begin
              err_acc <= 1'b1;
            end
          end
        end
        // A line close also discards any dangling high nibble.
        if (line_end) begin
          line_cnt     <= sat_inc(line_cnt);
          last_len_int <= line_bytes;
          line_bytes   <= '0;
          phase        <= 1'b0;
          if (phase || (line_bytes != WIDTH_V)) err_acc <= 1'b1;
        end
      end
      if (state == DONE) begin
        line_count    <= line_cnt;
        last_line_len <= last_len_int;
        frame_err     <= err_acc || (line_cnt != HEIGHT_V);
      end
    end
  end

endmodule

// File: tb/tb_hm01b0_capture_ctrl.sv
// Randomized bench for hm01b0_capture_ctrl against a frame-level reference model.
// Reduced geometry keeps full frames short; HM01B0_CAPTURE_DECIMATE_EN selects the subsampled model.
module tb_hm01b0_capture_ctrl;
  localparam int TW = 10;
  localparam int TH = 6;
  localparam int TA = 17;
`ifdef HM01B0_CAPTURE_DECIMATE_EN
  localparam bit DECIM = 1'b1;
  localparam int LIMIT = (TW / 2) * (TH / 2);
`else
  localparam bit DECIM = 1'b0;
  localparam int LIMIT = TW * TH;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] pixdata = '0;
  logic hsync = 1'b0, vsync = 1'b0, arm = 1'b0, continuous = 1'b0;
  logic wr_en, busy, frame_done, frame_err;
  logic [TA-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [15:0] line_count, last_line_len;

  hm01b0_capture_ctrl #(.WIDTH(TW), .HEIGHT(TH), .ADDR_W(TA)) dut (
    .hm01b0_pixclk(clk), .reset(reset), .pixdata(pixdata), .hsync(hsync), .vsync(vsync),
    .arm(arm), .continuous(continuous), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .line_count(line_count), .last_line_len(last_line_len)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [7:0] data; } wr_t;
  wr_t        wr_q[$];
  int         line_nib[$];
  logic [3:0] nib_q[$];
  int         done_cnt = 0;
  int         max_addr = 0;
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_q.push_back('{int'(wr_addr), wr_data});
      if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
    end
    if (frame_done) done_cnt++;
  end

  task automatic clear_obs();
    wr_q.delete();
    nib_q.delete();
    line_nib.delete();
    done_cnt = 0;
    max_addr = 0;
  endtask

  task automatic drive_frame(input bit pattern, input bit tight, input bit drop_arm);
    logic [3:0] nv;
    @(negedge clk);
    vsync = 1'b1;
    hsync = 1'b0;
    if (drop_arm) arm = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < line_nib.size(); l++) begin
      for (int n = 0; n < line_nib[l]; n++) begin
        nv = pattern ? ((n % 2 == 0) ? 4'hA : 4'h5) : 4'($urandom_range(0, 15));
        hsync = 1'b1;
        pixdata = nv;
        nib_q.push_back(nv);
        @(negedge clk);
      end
      if (!(tight && l == line_nib.size() - 1)) begin
        hsync = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    hsync = 1'b0;
    vsync = 1'b0;
    pixdata = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input bit exp_busy);
    wr_t exp_q[$];
    int wc = 0, pos = 0, nb, bad = -1;
    bit err = 1'b0, keep;
    logic [7:0] d;
    for (int l = 0; l < line_nib.size(); l++) begin
      nb = line_nib[l] / 2;
      if ((line_nib[l] % 2) != 0 || nb != TW) err = 1'b1;
      for (int b = 0; b < nb; b++) begin
        d = {nib_q[pos + 2 * b], nib_q[pos + 2 * b + 1]};
        keep = DECIM ? (l % 2 == 0 && b % 2 == 0) : 1'b1;
        if (keep) begin
          if (wc < LIMIT) begin
            exp_q.push_back('{wc, d});
            wc++;
          end else err = 1'b1;
        end
      end
      pos += line_nib[l];
    end
    if (line_nib.size() != TH) err = 1'b1;

    tests++;
    if (wr_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL %s write_count got %0d want %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s write_content idx %0d got addr %0d data %h want addr %0d data %h",
               name, bad, wr_q[bad].addr, wr_q[bad].data, exp_q[bad].addr, exp_q[bad].data);
    end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL %s frame_done_pulses got %0d want 1", name, done_cnt); end
    tests++;
    if (line_count !== 16'(line_nib.size())) begin
      fails++; $display("FAIL %s line_count got %0d want %0d", name, line_count, line_nib.size());
    end
    tests++;
    if (last_line_len !== 16'(line_nib[line_nib.size() - 1] / 2)) begin
      fails++; $display("FAIL %s last_line_len got %0d want %0d", name, last_line_len, line_nib[line_nib.size() - 1] / 2);
    end
    tests++;
    if (frame_err !== err) begin fails++; $display("FAIL %s frame_err got %b want %b", name, frame_err, err); end
    tests++;
    if (busy !== exp_busy) begin fails++; $display("FAIL %s busy got %b want %b", name, busy, exp_busy); end
    tests++;
    if (wr_q.size() > 0 && max_addr > LIMIT - 1) begin
      fails++; $display("FAIL %s max_addr got %0d want <= %0d", name, max_addr, LIMIT - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); arm = 1'($urandom); pixdata = 4'($urandom);
    end
    @(negedge clk);
    tests++;
    if ({wr_en, wr_addr, wr_data, frame_done, frame_err, line_count, last_line_len} !== '0) begin
      fails++; $display("FAIL reset_outputs got en=%b addr=%0d data=%h done=%b err=%b lc=%0d ll=%0d want all 0",
                        wr_en, wr_addr, wr_data, frame_done, frame_err, line_count, last_line_len);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    hsync = 1'b0; vsync = 1'b0; arm = 1'b0; pixdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_frame();
    clear_obs();
    continuous = 1'b0;
    arm = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < TH; l++) line_nib.push_back(2 * TW);
    drive_frame(1'b1, 1'b0, 1'b1);
    check_frame("clean_a5", 1'b0);
  endtask

  task automatic test_arm_mid_frame();
    clear_obs();
    @(negedge clk);
    vsync = 1'b1;
    for (int c = 0; c < 30; c++) begin
      hsync = (c % 12) < 8;
      pixdata = 4'($urandom);
      if (c == 10) arm = 1'b1;
      @(negedge clk);
    end
    hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_q.size() !== 0) begin fails++; $display("FAIL mid_frame_no_writes got %0d want 0", wr_q.size()); end
    for (int l = 0; l < TH; l++) line_nib.push_back(2 * TW);
    drive_frame(1'b0, 1'b0, 1'b1);
    check_frame("arm_mid_frame", 1'b0);
  endtask

  task automatic test_geometry_err();
    clear_obs();
    arm = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < TH; l++)
      line_nib.push_back((l == 1) ? 2 * (TW - 1) : (l == TH - 1) ? 2 * TW - 1 : 2 * TW);
    drive_frame(1'b0, 1'b1, 1'b1);
    check_frame("geometry_err", 1'b0);
  endtask

  task automatic test_overflow();
    clear_obs();
    arm = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < TH + 2; l++) line_nib.push_back(2 * TW);
    drive_frame(1'b0, 1'b1, 1'b1);
    check_frame("overflow", 1'b0);
  endtask

  task automatic test_continuous_reset();
    int n;
    clear_obs();
    continuous = 1'b1;
    arm = 1'b1;
    repeat (3) @(negedge clk);
    for (int l = 0; l < TH; l++) line_nib.push_back(2 * TW);
    drive_frame(1'b0, 1'b0, 1'b0);
    drive_frame(1'b0, 1'b0, 1'b0);
    tests++;
    if (done_cnt !== 2) begin fails++; $display("FAIL cont_done_pulses got %0d want 2", done_cnt); end
    tests++;
    if (wr_q.size() !== 2 * LIMIT) begin fails++; $display("FAIL cont_write_count got %0d want %0d", wr_q.size(), 2 * LIMIT); end
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      hsync = 1'b1; pixdata = 4'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    pixdata = 4'($urandom);
    #1 n = wr_q.size();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pixdata = 4'($urandom);
    end
    tests++;
    if (wr_q.size() !== n) begin fails++; $display("FAIL abort_no_writes got %0d want %0d", wr_q.size(), n); end
    tests++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err, line_count, last_line_len} !== '0) begin
      fails++; $display("FAIL abort_outputs got en=%b addr=%0d busy=%b err=%b lc=%0d want all 0",
                        wr_en, wr_addr, busy, frame_err, line_count);
    end
    reset = 1'b1; continuous = 1'b0; arm = 1'b0; vsync = 1'b0; hsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_arm_mid_frame();
    test_geometry_err();
    test_overflow();
    test_continuous_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
